// File: rtl/mem_access_ctrl_if.sv
// Pipeline-side and data-bus-side signals of the MEM-stage load/store sequencer.
// The controller uses the slave view; whoever drives the pipeline and models the
// bus (CPU top or a testbench) uses the master view.
interface mem_access_ctrl_if;
    logic        mem_op_valid;
    logic        mem_we;
    logic [2:0]  ld_sel;
    logic [1:0]  st_sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        exc_valid;
    logic [4:0]  exc_code;

    modport slave (
        input  mem_op_valid, mem_we, ld_sel, st_sel, addr, wdata, flush, bus_ack, bus_rdata,
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata, stall, ld_valid, ld_data,
        output exc_valid, exc_code
    );

    modport master (
        output mem_op_valid, mem_we, ld_sel, st_sel, addr, wdata, flush, bus_ack, bus_rdata,
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata, stall, ld_valid, ld_data,
        input  exc_valid, exc_code
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: alignment check, req/ack bus transaction with
// timeout, load byte-select/extension, and AdEL/AdES/DBE exception reporting.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input logic              clk,
    input logic              reset,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] LP_SZ_BYTE  = 2'd0;
    localparam logic [1:0] LP_SZ_HALF  = 2'd1;
    localparam logic [1:0] LP_SZ_WORD  = 2'd2;
    localparam logic [7:0] LP_CNT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] LP_EXC_ADEL = 5'd4;
    localparam logic [4:0] LP_EXC_ADES = 5'd5;
    localparam logic [4:0] LP_EXC_DBE  = 5'd7;

    // Access width class of the operation (unused encodings fall back to word).
    function automatic logic [1:0] f_access_size(input logic we, input logic [2:0] ld_sel,
                                                 input logic [1:0] st_sel);
        logic [1:0] sz;
        if (we) begin
            case (st_sel)
                2'd1:    sz = LP_SZ_HALF;
                2'd2:    sz = LP_SZ_BYTE;
                default: sz = LP_SZ_WORD;
            endcase
        end else begin
            case (ld_sel)
                3'd1, 3'd2: sz = LP_SZ_HALF;
                3'd3, 3'd4: sz = LP_SZ_BYTE;
                default:    sz = LP_SZ_WORD;
            endcase
        end
        return sz;
    endfunction

    // Natural alignment check for the given width class.
    function automatic logic f_aligned(input logic [1:0] sz, input logic [1:0] a);
        logic ok;
        case (sz)
            LP_SZ_WORD: ok = (a == 2'd0);
            LP_SZ_HALF: ok = (a[0] == 1'b0);
            default:    ok = 1'b1;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by a store.
    function automatic logic [3:0] f_store_be(input logic [1:0] st_sel, input logic [1:0] a);
        logic [3:0] be;
        case (st_sel)
            2'd1:    be = a[1] ? 4'b1100 : 4'b0011;
            2'd2:    be = 4'b0001 << a;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Store data replicated onto every lane so the enabled lanes carry it.
    function automatic logic [31:0] f_store_wdata(input logic [1:0] st_sel, input logic [31:0] wd);
        logic [31:0] d;
        case (st_sel)
            2'd1:    d = {wd[15:0], wd[15:0]};
            2'd2:    d = {4{wd[7:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Select the addressed halfword/byte from the read word and extend it.
    function automatic logic [31:0] f_extract(input logic [2:0] ld_sel, input logic [1:0] a,
                                              input logic [31:0] rd);
        logic [15:0] h;
        logic [7:0]  b;
        logic [31:0] r;
        h = a[1] ? rd[31:16] : rd[15:0];
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        case (ld_sel)
            3'd1:    r = {{16{h[15]}}, h};
            3'd2:    r = {16'h0000, h};
            3'd3:    r = {{24{b[7]}}, b};
            3'd4:    r = {24'h000000, b};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t      r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [1:0]  r_a, w_a_nxt;
    logic [2:0]  r_ld_sel, w_ld_sel_nxt;
    logic        r_we, w_we_nxt;
    logic        r_flushed, w_flushed_nxt;
    logic        r_bus_req, w_bus_req_nxt;
    logic        r_bus_we, w_bus_we_nxt;
    logic [31:0] r_bus_addr, w_bus_addr_nxt;
    logic [3:0]  r_bus_be, w_bus_be_nxt;
    logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
    logic        r_ld_valid, w_ld_valid_nxt;
    logic [31:0] r_ld_data, w_ld_data_nxt;
    logic        r_exc_valid, w_exc_valid_nxt;
    logic [4:0]  r_exc_code, w_exc_code_nxt;
    logic        w_stall;
    logic        w_aligned;

    assign w_aligned = f_aligned(f_access_size(bus.mem_we, bus.ld_sel, bus.st_sel), bus.addr[1:0]);

    // Next-state, stall and next-value logic for every registered output.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_a_nxt         = r_a;
        w_ld_sel_nxt    = r_ld_sel;
        w_we_nxt        = r_we;
        w_flushed_nxt   = r_flushed;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_be_nxt    = r_bus_be;
        w_bus_wdata_nxt = r_bus_wdata;
        w_ld_valid_nxt  = 1'b0;
        w_ld_data_nxt   = r_ld_data;
        w_exc_valid_nxt = 1'b0;
        w_exc_code_nxt  = 5'd0;
        w_stall         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.mem_op_valid && !bus.flush) begin
                    w_stall      = 1'b1;
                    w_a_nxt      = bus.addr[1:0];
                    w_ld_sel_nxt = bus.ld_sel;
                    w_we_nxt     = bus.mem_we;
                    if (w_aligned) begin
                        w_state_nxt     = ST_REQ;
                        w_cnt_nxt       = 8'd0;
                        w_flushed_nxt   = 1'b0;
                        w_bus_req_nxt   = 1'b1;
                        w_bus_we_nxt    = bus.mem_we;
                        w_bus_addr_nxt  = {bus.addr[31:2], 2'b00};
                        w_bus_be_nxt    = bus.mem_we ? f_store_be(bus.st_sel, bus.addr[1:0]) : 4'b1111;
                        w_bus_wdata_nxt = bus.mem_we ? f_store_wdata(bus.st_sel, bus.wdata) : 32'd0;
                    end else begin
                        // Misaligned: report straight away, the bus is never touched.
                        w_state_nxt     = ST_ERR;
                        w_exc_valid_nxt = 1'b1;
                        w_exc_code_nxt  = bus.mem_we ? LP_EXC_ADES : LP_EXC_ADEL;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                w_stall = 1'b1;
                // The bus cannot withdraw a request, so a flush only suppresses the result.
                w_flushed_nxt = r_flushed | bus.flush;
                if (bus.bus_ack) begin
                    w_state_nxt     = ST_DONE;
                    w_bus_req_nxt   = 1'b0;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_addr_nxt  = 32'd0;
                    w_bus_be_nxt    = 4'd0;
                    w_bus_wdata_nxt = 32'd0;
                    if (!r_we) begin
                        w_ld_data_nxt  = f_extract(r_ld_sel, r_a, bus.bus_rdata);
                        w_ld_valid_nxt = ~(r_flushed | bus.flush);
                    end else begin
                        w_ld_valid_nxt = 1'b0;
                    end
                end else if (r_cnt == LP_CNT_LAST) begin
                    w_state_nxt     = ST_ERR;
                    w_bus_req_nxt   = 1'b0;
                    w_bus_we_nxt    = 1'b0;
                    w_bus_addr_nxt  = 32'd0;
                    w_bus_be_nxt    = 4'd0;
                    w_bus_wdata_nxt = 32'd0;
                    w_exc_valid_nxt = ~(r_flushed | bus.flush);
                    w_exc_code_nxt  = LP_EXC_DBE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            ST_DONE, ST_ERR: begin
                w_state_nxt   = ST_IDLE;
                w_flushed_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 8'd0;
            r_a         <= 2'd0;
            r_ld_sel    <= 3'd0;
            r_we        <= 1'b0;
            r_flushed   <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_ld_valid  <= 1'b0;
            r_ld_data   <= 32'd0;
            r_exc_valid <= 1'b0;
            r_exc_code  <= 5'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_a         <= w_a_nxt;
            r_ld_sel    <= w_ld_sel_nxt;
            r_we        <= w_we_nxt;
            r_flushed   <= w_flushed_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_be    <= w_bus_be_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_ld_valid  <= w_ld_valid_nxt;
            r_ld_data   <= w_ld_data_nxt;
            r_exc_valid <= w_exc_valid_nxt;
            r_exc_code  <= w_exc_code_nxt;
        end
    end

    assign bus.bus_req   = r_bus_req;
    assign bus.bus_we    = r_bus_we;
    assign bus.bus_addr  = r_bus_addr;
    assign bus.bus_be    = r_bus_be;
    assign bus.bus_wdata = r_bus_wdata;
    assign bus.stall     = w_stall;
    assign bus.ld_data   = r_ld_data;
    assign bus.exc_code  = r_exc_code;
    // A CP0 flush arriving in the result cycle itself still cancels the result.
    assign bus.ld_valid  = r_ld_valid & ~bus.flush;
    assign bus.exc_valid = r_exc_valid & ~bus.flush;
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Multi-cycle load/store sequencer in the MEM stage of the pipelined MIPS CPU.
- Checks alignment, drives a req/ack data bus shared by DM and MMIO devices, and stalls the pipeline until the bus acknowledges.
- Byte-selects and sign/zero-extends load data, and raises AdEL/AdES/bus-timeout exceptions towards CP0.

Parameters:
- TIMEOUT_CYCLES, 15, max REQ cycles without bus_ack before a bus-error exception (range 2..255).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- mem_op_valid  in  1  MEM-stage instruction is a load or store
- mem_we  in  1  1 = store, 0 = load
- ld_sel  in  3  load type: 0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu; 5-7 treated as lw
- st_sel  in  2  store type: 0 sw, 1 sh, 2 sb; 3 treated as sw
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- flush  in  1  exception flush from CP0
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  word address, {addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion, one cycle
- bus_rdata  in  32  read word, valid with bus_ack
- stall  out  1  freeze IF..MEM stages
- ld_valid  out  1  ld_data valid this cycle
- ld_data  out  32  extended load result
- exc_valid  out  1  exception this cycle
- exc_code  out  5  4 AdEL, 5 AdES, 7 bus error (DBE)

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE, counter 0, all registered outputs 0.
- bus_req, bus_we, bus_addr, bus_be, bus_wdata, ld_valid, ld_data, exc_valid and exc_code are registered.
- stall is combinational.
- States:
  - IDLE: waiting for mem_op_valid.
  - REQ: bus transaction outstanding.
  - DONE: one-cycle result; ld_valid=1 for loads.
  - ERR: one-cycle exception; exc_valid=1.
- Alignment:
  - Word access requires addr[1:0]==0.
  - Halfword access requires addr[0]==0.
  - Byte access is always aligned.
- IDLE, mem_op_valid=1, flush=0, aligned:
  - stall=1 in that cycle.
  - Latch addr[1:0], ld_sel, mem_we.
  - Next cycle: REQ with bus_req=1.
- IDLE, mem_op_valid=1, flush=0, misaligned:
  - stall=1.
  - Next cycle: ERR with exc_code 4 (load) or 5 (store).
  - No bus_req is issued.
- IDLE, flush=1: remain in IDLE; mem_op_valid is ignored.
- REQ:
  - stall=1; bus outputs are held stable until bus_ack.
  - Counter increments every cycle without bus_ack.
  - bus_ack=1: bus_req=0 next cycle; state goes to DONE.
  - For loads, ld_data is registered from bus_rdata.
  - Counter == TIMEOUT_CYCLES-1 and no ack: go to ERR with exc_code 7, bus_req=0.
  - Ack and timeout limit in the same cycle: ack wins.
- DONE / ERR:
  - stall=0 so the pipeline advances.
  - Return to IDLE unconditionally next cycle.
  - ld_valid and exc_valid are high for exactly one cycle.
- Load extraction (latched A=addr[1:0]):
  - lw: whole word.
  - lh / lhu: A[1] ? rdata[31:16] : rdata[15:0].
  - lb / lbu: byte A selected as rdata[8A+7:8A].
  - lh/lb sign-extend; lhu/lbu zero-extend to 32.
- Stores:
  - sw: bus_be=1111, bus_wdata=wdata.
  - sh: bus_be = A[1] ? 1100 : 0011; bus_wdata = {wdata[15:0], wdata[15:0]}.
  - sb: bus_be = 0001<<A; bus_wdata = {4{wdata[7:0]}}.
  - Loads: bus_be=1111, bus_we=0.
- Flush during REQ:
  - The request is not withdrawn (the bus forbids it).
  - A sticky flushed flag is set; the transaction completes normally or times out.
  - DONE/ERR then assert neither ld_valid nor exc_valid.
  - stall follows normal REQ/DONE/ERR rules.
- Flush in DONE/ERR: suppresses ld_valid/exc_valid that cycle; next state is IDLE.
- Reset mid-transaction: return to IDLE immediately, bus_req=0. The bus is reset by the same signal.
- Throughput: minimum 3 cycles per access (IDLE, REQ with immediate ack, DONE).

Test Plan:
- lb at addr 0x0000_0003, bus_rdata 0x80FF_1234, ack on first REQ cycle -> stall high 2 cycles, ld_valid 1 cycle, ld_data 0xFFFF_FF80; lbu same -> 0x0000_0080.
- lh at addr 0x0000_0002, rdata 0x8001_7FFF -> ld_data 0xFFFF_8001; lhu -> 0x0000_8001; lh at 0x0000_0001 -> no bus_req, exc_valid with exc_code 4.
- sb wdata 0x1234_56AB at addr 0x0000_0102 -> bus_addr 0x0000_0100, bus_be 0100, bus_wdata 0xABAB_ABAB, bus_we 1; sw at 0x0000_0006 -> exc_code 5, no bus_req.
- Load with bus_ack never asserted, TIMEOUT_CYCLES=15 -> bus_req high exactly 15 cycles, then exc_code 7 for one cycle, stall released.
- flush asserted during the 2nd REQ cycle, ack on the 4th -> bus_req held until ack, no ld_valid/exc_valid, state IDLE afterwards.
- reset=0 during REQ -> next cycle bus_req=0, stall=0, all outputs 0; a fresh lw at 0x0000_0010 afterwards completes normally.
